// File: rtl/wheel_period_meas.sv
// Wheel-sensor period meter: prescaled tick counter between pulses, revolution count, stop detect.
// Optional build macro PERIOD_GLITCH_REJECT_EN ignores pulses arriving sooner than MIN_TICKS.
module wheel_period_meas #(
    parameter int PRESCALE      = 50000,
    parameter int PER_W         = 16,
    parameter int TIMEOUT_TICKS = 3000,
    parameter int MIN_TICKS     = 40,
    parameter int REV_W         = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             stopped,
    output logic [REV_W-1:0] rev_cnt
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [PER_W-1:0] TO_LAST  = PER_W'(TIMEOUT_TICKS - 1);
    localparam logic [PER_W-1:0] TICK_MAX = {PER_W{1'b1}};

    typedef enum logic {
        S_IDLE,
        S_MEAS
    } state_t;

    state_t           state, state_nxt;
    logic [PRE_W-1:0] pre_cnt, pre_cnt_nxt;
    logic [PER_W-1:0] tick_cnt, tick_cnt_nxt;
    logic [PER_W-1:0] period_nxt;
    logic             period_vld_nxt;
    logic             stopped_nxt;
    logic [REV_W-1:0] rev_cnt_nxt;

    logic tick;
    logic timeout;
    logic accept;

    assign tick    = (state == S_MEAS) && (pre_cnt == PRE_LAST);
    assign timeout = tick && (tick_cnt == TO_LAST);

`ifdef PERIOD_GLITCH_REJECT_EN
    assign accept = pulse_in && ((state == S_IDLE) || (tick_cnt >= PER_W'(MIN_TICKS)));
`else
    assign accept = pulse_in;
`endif

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt      = state;
        pre_cnt_nxt    = pre_cnt;
        tick_cnt_nxt   = tick_cnt;
        period_nxt     = period;
        period_vld_nxt = 1'b0;
        stopped_nxt    = stopped;
        rev_cnt_nxt    = rev_cnt;

        // The pulse cycle is the first clock of the new interval, so pulses spaced
        // N*PRESCALE clocks apart land between ticks and measure exactly N.
        case (state)
            S_IDLE: begin
                pre_cnt_nxt  = '0;
                tick_cnt_nxt = '0;
                stopped_nxt  = 1'b1;
                if (accept) begin
                    state_nxt   = S_MEAS;
                    pre_cnt_nxt = PRE_ONE;
                    stopped_nxt = 1'b0;
                    rev_cnt_nxt = rev_cnt + 1'b1;
                end
            end
            S_MEAS: begin
                if (accept) begin
                    period_nxt     = tick_cnt;
                    period_vld_nxt = 1'b1;
                    pre_cnt_nxt    = PRE_ONE;
                    tick_cnt_nxt   = '0;
                    rev_cnt_nxt    = rev_cnt + 1'b1;
                end else if (timeout) begin
                    state_nxt    = S_IDLE;
                    stopped_nxt  = 1'b1;
                    period_nxt   = '0;
                    pre_cnt_nxt  = '0;
                    tick_cnt_nxt = '0;
                end else begin
                    pre_cnt_nxt = tick ? '0 : pre_cnt + 1'b1;
                    if (tick && (tick_cnt != TICK_MAX)) begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pre_cnt    <= '0;
            tick_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            stopped    <= 1'b1;
            rev_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            pre_cnt    <= pre_cnt_nxt;
            tick_cnt   <= tick_cnt_nxt;
            period     <= period_nxt;
            period_vld <= period_vld_nxt;
            stopped    <= stopped_nxt;
            rev_cnt    <= rev_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wheel_period_meas.sv
// Bench for wheel_period_meas: clock-distance reference model checked every cycle,
// directed scenarios with literal expectations, then randomized pulse gaps and resets.
module tb_wheel_period_meas;

    localparam int P    = 4;
    localparam int T    = 20;
    localparam int MINT = 3;
    localparam int PW   = 8;
    localparam int RW   = 4;

`ifdef PERIOD_GLITCH_REJECT_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_in = 1'b0;
    logic [PW-1:0] period;
    logic          period_vld;
    logic          stopped;
    logic [RW-1:0] rev_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    wheel_period_meas #(
        .PRESCALE     (P),
        .PER_W        (PW),
        .TIMEOUT_TICKS(T),
        .MIN_TICKS    (MINT),
        .REV_W        (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in),
        .period    (period),
        .period_vld(period_vld),
        .stopped   (stopped),
        .rev_cnt   (rev_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks clocks elapsed since the last accepted pulse; the
    // period is that distance divided by the prescale, timeout at T*P-1 clocks.
    bit            m_meas;
    int            m_since;
    logic [PW-1:0] m_period;
    logic          m_vld;
    logic          m_stopped;
    logic [RW-1:0] m_rev;

    always @(posedge clk) begin
        if (rst) begin
            m_meas <= 1'b0; m_since <= 0; m_period <= '0;
            m_vld <= 1'b0; m_stopped <= 1'b1; m_rev <= '0;
        end else if (!m_meas) begin
            m_vld <= 1'b0;
            if (pulse_in) begin
                m_meas <= 1'b1; m_since <= 0; m_stopped <= 1'b0; m_rev <= m_rev + 1'b1;
            end
        end else if (pulse_in && (!GLITCH || ((m_since + 1) / P) >= MINT)) begin
            m_period <= PW'((m_since + 1) / P);
            m_vld    <= 1'b1;
            m_rev    <= m_rev + 1'b1;
            m_since  <= 0;
        end else if (m_since + 1 == T * P - 1) begin
            m_meas <= 1'b0; m_stopped <= 1'b1; m_period <= '0; m_vld <= 1'b0;
        end else begin
            m_since <= m_since + 1;
            m_vld   <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("period", 32'(period), 32'(m_period));
        check("period_vld", 32'(period_vld), 32'(m_vld));
        check("stopped", 32'(stopped), 32'(m_stopped));
        check("rev_cnt", 32'(rev_cnt), 32'(m_rev));
    end

    // Drive one clock with the given pulse value; returns at the following negedge.
    task automatic step(input logic p);
        pulse_in = p;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Idle until edge k, then drive pulse value p on edge k.
    task automatic run_to(input int k, input logic p);
        while (cyc < k - 1) step(1'b0);
        step(p);
    endtask

    initial begin
        int gap;

        // 1: no pulses after reset
        do_reset();
        run_to(30, 1'b0);
        check("s1_stopped", 32'(stopped), 32'd1);
        check("s1_period", 32'(period), 32'd0);
        check("s1_rev", 32'(rev_cnt), 32'd0);

        // 2: pulses at 10 and 50
        do_reset();
        run_to(10, 1'b1);
        check("s2_rev1", 32'(rev_cnt), 32'd1);
        check("s2_novld", 32'(period_vld), 32'd0);
        run_to(50, 1'b1);
        check("s2_vld", 32'(period_vld), 32'd1);
        check("s2_period", 32'(period), 32'd10);
        check("s2_rev2", 32'(rev_cnt), 32'd2);
        check("s2_stopped", 32'(stopped), 32'd0);

        // 3: timeout after a single pulse
        do_reset();
        run_to(10, 1'b1);
        run_to(90, 1'b0);
        check("s3_stopped", 32'(stopped), 32'd1);
        check("s3_period", 32'(period), 32'd0);
        run_to(100, 1'b1);
        check("s3_novld", 32'(period_vld), 32'd0);
        check("s3_rev", 32'(rev_cnt), 32'd2);

        // 4: pulses 8 clocks apart
        do_reset();
        run_to(10, 1'b1);
        run_to(18, 1'b1);
`ifdef PERIOD_GLITCH_REJECT_EN
        check("s4_rev", 32'(rev_cnt), 32'd1);
        check("s4_novld", 32'(period_vld), 32'd0);
`else
        check("s4_rev", 32'(rev_cnt), 32'd2);
        check("s4_period", 32'(period), 32'd2);
        check("s4_vld", 32'(period_vld), 32'd1);
`endif

        // 5: revolution counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_to(10 + 40 * i, 1'b1);
            check("s5_rev", 32'(rev_cnt), 32'((i + 1) % 16));
            if (i > 0) check("s5_period", 32'(period), 32'd10);
        end

        // 6: reset mid-measurement
        do_reset();
        run_to(10, 1'b1);
        run_to(32, 1'b0);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        cyc = 0;
        check("s6_rst_rev", 32'(rev_cnt), 32'd0);
        check("s6_rst_stopped", 32'(stopped), 32'd1);
        run_to(5, 1'b1);
        check("s6_novld", 32'(period_vld), 32'd0);
        run_to(45, 1'b1);
        check("s6_vld", 32'(period_vld), 32'd1);
        check("s6_period", 32'(period), 32'd10);
        check("s6_rev", 32'(rev_cnt), 32'd2);

        // 7: randomized gaps, including exact tick multiples and the timeout boundary
        do_reset();
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       gap = $urandom_range(2, 14);
                1:       gap = P * $urandom_range(1, T);
                2:       gap = T * P - 1 + $urandom_range(0, 1);
                default: gap = $urandom_range(2, 120);
            endcase
            repeat (gap - 1) step(1'b0);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                step(1'b0);
                rst = 1'b0;
            end else begin
                step(1'b1);
            end
        end
        repeat (5) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
